// File: rtl/conv1_layer1_dense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv1_layer1_dense_ctrl
// Description : Tile sequencer for the conv1 layer-1 dense path. Issues one
//               fetch per tile, tracks source data and multiplier result
//               strobes, hands each result to writeback over valid/ready and
//               flags protocol or timeout errors. One tile is in flight at a
//               time.
// Revision    : 1.0 - initial release
// ============================================================================
module conv1_layer1_dense_ctrl #(
    parameter int NUM_TILES = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       mx_start,
    output logic       need_data,
    input  logic       data_v,
    input  logic       mult_res_v,
    output logic       wb_valid,
    input  logic       wb_ready,
    output logic [7:0] tile_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Index of the final tile of a pass.
    localparam logic [7:0]  c_LAST_TILE  = 8'(NUM_TILES - 1);
    // The wait counter starts at 0 on entry, so the last permitted waiting
    // cycle is the one where it reads TIMEOUT-1.
    localparam logic [15:0] c_WAIT_LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_WAIT_RES  = 3'd3,
        S_WRITE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_tile_idx;
    logic [7:0]  w_tile_next;
    logic [15:0] r_wait_cnt;
    logic        r_err;
    logic        w_err_set;
    logic        w_err_clr;
    logic        w_strobe;
    logic        w_timeout;
    logic        w_in_wait;

    logic        r_mx_start;
    logic        r_need_data;
    logic        r_wb_valid;
    logic        r_busy;
    logic        r_done;

    assign w_strobe  = data_v | mult_res_v;
    assign w_in_wait = (r_state == S_WAIT_DATA) || (r_state == S_WAIT_RES);
    assign w_timeout = (r_wait_cnt == c_WAIT_LIMIT);

    // Next-state, tile index and error set/clear decisions; aborts are
    // checked first in every waiting state so they win over any other move.
    always_comb begin
        w_state_next = r_state;
        w_tile_next  = r_tile_idx;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    // Stray source/multiplier strobe while idle: flag and stay.
                    w_err_set = 1'b1;
                end else if (start) begin
                    w_state_next = S_FETCH;
                    w_tile_next  = 8'd0;
                    w_err_clr    = 1'b1;
                end
            end
            S_FETCH: begin
                if (mult_res_v) begin
                    // A result before any data is a protocol violation.
                    w_err_set    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (data_v) begin
                    // Zero-latency source answered in the fetch cycle.
                    w_state_next = S_WAIT_RES;
                end else begin
                    w_state_next = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (mult_res_v) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (data_v) begin
                    w_state_next = S_WAIT_RES;
                end else if (w_timeout) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_RES: begin
                if (data_v) begin
                    // Duplicate data for a tile already fetched.
                    w_err_set    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (mult_res_v) begin
                    w_state_next = S_WRITE;
                end else if (w_timeout) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                // Strobes here are flagged but the pass carries on.
                if (w_strobe) begin
                    w_err_set = 1'b1;
                end
                if (wb_ready) begin
                    if (r_tile_idx == c_LAST_TILE) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_tile_next  = r_tile_idx + 8'd1;
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (w_strobe) begin
                    w_err_set = 1'b1;
                end
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, tile index, wait counter, sticky error and the state-decoded
    // outputs, all registered from the next-state decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tile_idx  <= 8'd0;
            r_wait_cnt  <= 16'd0;
            r_err       <= 1'b0;
            r_mx_start  <= 1'b0;
            r_need_data <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tile_idx <= w_tile_next;

            // Counter restarts on every entry into a waiting state and only
            // advances while the state is unchanged.
            if (w_in_wait && (w_state_next == r_state)) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                r_wait_cnt <= 16'd0;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end

            r_need_data <= (w_state_next == S_FETCH);
            r_mx_start  <= (w_state_next == S_FETCH) && (w_tile_next == 8'd0);
            r_wb_valid  <= (w_state_next == S_WRITE);
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= (w_state_next == S_DONE);
        end
    end

    assign mx_start  = r_mx_start;
    assign need_data = r_need_data;
    assign wb_valid  = r_wb_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign tile_idx  = r_tile_idx;

endmodule
`default_nettype wire

// File: tb/tb_conv1_layer1_dense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv1_layer1_dense_ctrl
// Description : Scoreboard bench for conv1_layer1_dense_ctrl. The driver acts
//               as source, multiplier and writeback with random latencies and
//               pushes the event sequence each pass must produce; a monitor
//               pops and compares events and checks cycle relationships.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv1_layer1_dense_ctrl;

    localparam int N  = 4;
    localparam int TO = 8;

    localparam int EV_NEED = 0;
    localparam int EV_WB   = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int tile;
        bit mx;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       data_v = 1'b0;
    logic       mult_res_v = 1'b0;
    logic       wb_ready = 1'b0;
    logic       mx_start;
    logic       need_data;
    logic       wb_valid;
    logic [7:0] tile_idx;
    logic       busy;
    logic       done;
    logic       err;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    bit  legit_mres = 1'b0;
    ev_t exp_q[$];

    conv1_layer1_dense_ctrl #(
        .NUM_TILES (N),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mx_start   (mx_start),
        .need_data  (need_data),
        .data_v     (data_v),
        .mult_res_v (mult_res_v),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .tile_idx   (tile_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int tile, input bit mx);
        ev_t e;
        e.kind = kind;
        e.tile = tile;
        e.mx   = mx;
        exp_q.push_back(e);
    endtask

    // A complete pass: fetch then write for every tile in order, then done.
    task automatic push_pass();
        for (int k = 0; k < N; k++) begin
            push_ev(EV_NEED, k, k == 0);
            push_ev(EV_WB, k, 1'b0);
        end
        push_ev(EV_DONE, 0, 1'b0);
    endtask

    task automatic pop_cmp(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got event %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", kind, e.kind);
            if (kind == EV_NEED) begin
                check("sb_need_tile", tile_idx, e.tile);
                check("sb_need_mx", mx_start, e.mx);
            end else if (kind == EV_WB) begin
                check("sb_wb_tile", tile_idx, e.tile);
            end
        end
    endtask

    // Monitor: samples on the falling edge, pops scoreboard events and checks
    // one-cycle response rules against the inputs seen the cycle before.
    initial begin
        bit p_rst, p_start_acc, p_hs, p_last, p_wbv_hold, p_legit;
        p_rst = 1'b1; p_start_acc = 1'b0; p_hs = 1'b0;
        p_last = 1'b0; p_wbv_hold = 1'b0; p_legit = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!p_rst) begin
                    check("need_timing", need_data, p_start_acc || (p_hs && !p_last));
                    check("done_timing", done, p_hs && p_last);
                    check("wbv_timing", wb_valid, p_wbv_hold || p_legit);
                    if (!need_data) check("mx_without_need", mx_start, 1'b0);
                end
                if (need_data === 1'b1) pop_cmp(EV_NEED);
                if (wb_valid === 1'b1 && wb_ready === 1'b1) pop_cmp(EV_WB);
                if (done === 1'b1) pop_cmp(EV_DONE);
            end
            p_rst       = rst;
            p_start_acc = start && !busy && !rst && !data_v && !mult_res_v;
            p_hs        = wb_valid && wb_ready && !rst;
            p_last      = (tile_idx == 8'(N - 1));
            p_wbv_hold  = wb_valid && !wb_ready && !rst;
            p_legit     = legit_mres && mult_res_v && !rst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_need();
        int n;
        n = 0;
        while (!need_data && n < 20) begin
            tick();
            n++;
        end
        check("need_wait_bound", need_data, 1'b1);
    endtask

    // One full pass. fast: zero-latency source, next-cycle result, no
    // backpressure. strobe_wr: stray data_v while tile 1 sits in writeback.
    task automatic run_pass(input bit fast, input bit strobe_wr);
        int dl, ml, rl, c0;
        push_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_err", err, 1'b0);
        check("first_tile_idx", tile_idx, 0);
        c0 = cyc;
        for (int k = 0; k < N; k++) begin
            wait_need();
            dl = fast ? 0 : int'($urandom_range(0, 4));
            ml = fast ? 1 : int'($urandom_range(1, 4));
            rl = fast ? 0 : int'($urandom_range(0, 5));
            repeat (dl) tick();
            data_v = 1'b1;
            tick();
            data_v = 1'b0;
            repeat (ml - 1) tick();
            mult_res_v = 1'b1;
            legit_mres = 1'b1;
            start = fast ? 1'b0 : ($urandom_range(0, 3) == 0);
            tick();
            mult_res_v = 1'b0;
            legit_mres = 1'b0;
            start = 1'b0;
            if (strobe_wr && k == 1) data_v = 1'b1;
            repeat (rl) begin
                tick();
                data_v = 1'b0;
                check("wb_hold_tile", tile_idx, k);
            end
            wb_ready = 1'b1;
            tick();
            wb_ready = 1'b0;
            data_v = 1'b0;
        end
        check("pass_done", done, 1'b1);
        check("pass_err", err, strobe_wr);
        if (fast) check("min_pass_cycles", cyc - c0 + 1, 3 * N + 1);
        tick();
        check("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_mx_start", mx_start, 1'b0);
        check("rst_need_data", need_data, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_tile_idx", tile_idx, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int p = 0; p < 3; p++) run_pass(1'b0, 1'b0);
        run_pass(1'b1, 1'b0);
        run_pass(1'b0, 1'b1);

        // Timeout in WAIT_DATA: no data ever arrives.
        push_ev(EV_NEED, 0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("to_err_before", err, 1'b0);
        check("to_busy_before", busy, 1'b1);
        tick();
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_done", done, 1'b0);
        tick();
        run_pass(1'b0, 1'b0);

        // Result strobe while waiting for data aborts.
        push_ev(EV_NEED, 0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mult_res_v = 1'b1;
        tick();
        mult_res_v = 1'b0;
        check("early_res_err", err, 1'b1);
        check("early_res_busy", busy, 1'b0);
        tick();
        run_pass(1'b0, 1'b0);

        // Data strobe while idle: error, remain idle.
        data_v = 1'b1;
        tick();
        data_v = 1'b0;
        check("idle_strobe_err", err, 1'b1);
        check("idle_strobe_busy", busy, 1'b0);
        tick();
        check("idle_strobe_stay", busy, 1'b0);
        run_pass(1'b0, 1'b0);

        // Duplicate data while waiting for the result aborts.
        push_ev(EV_NEED, 0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        data_v = 1'b1;
        tick();
        tick();
        data_v = 1'b0;
        check("dup_data_err", err, 1'b1);
        check("dup_data_busy", busy, 1'b0);
        tick();
        run_pass(1'b0, 1'b0);

        // Reset while tile 1 waits for its result.
        push_ev(EV_NEED, 0, 1'b1);
        push_ev(EV_WB, 0, 1'b0);
        push_ev(EV_NEED, 1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        data_v = 1'b1;
        tick();
        data_v = 1'b0;
        mult_res_v = 1'b1;
        legit_mres = 1'b1;
        tick();
        mult_res_v = 1'b0;
        legit_mres = 1'b0;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        data_v = 1'b1;
        tick();
        data_v = 1'b0;
        check("pre_rst_tile", tile_idx, 1);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_wb_valid", wb_valid, 1'b0);
        check("mid_rst_need", need_data, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_tile", tile_idx, 0);
        rst = 1'b0;
        tick();
        run_pass(1'b0, 1'b0);

        tick();
        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
